// File: rtl/axi_lite_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_regs
//
// AXI4-Lite slave register file for the AD9643 capture path. It provides
// NUM_REGS read/write 32-bit control registers, followed in the address map
// by NUM_STAT read-only 32-bit status registers. The read and write channels
// are independent. Byte strobes are honoured. Undecoded indices answer SLVERR.
//
// Register 0 bit 0 drives the ADC-path `reset` control.
// Register 0 bit 1 drives the ADC-path `data_en` control.
//
// Optional feature (compile-time macro AXI_LITE_REGS_WR_PULSE_EN):
//   When defined, the wr_pulse port exists. wr_pulse[i] is a one-cycle
//   registered strobe that follows every successful write to control
//   register i.
//   When undefined, the port and its logic are absent.
//
// Parameters:
//   NUM_REGS   number of R/W control registers at byte offsets 0x0, 0x4, ...
//   NUM_STAT   number of read-only status registers after the control block
//   ADDR_WIDTH decoded address bits. Bits [1:0] and bits above ADDR_WIDTH-1
//              are ignored.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_bready  write address / data / response inputs
//   m_axi_awready/wready/bvalid/bresp  write channel outputs
//   s_axi_ar*/s_axi_rready         read address / response inputs
//   m_axi_arready/rvalid/rdata/rresp   read channel outputs
//   stat_in   NUM_STAT*32 status values, sampled at the AR handshake
//   reg_out   NUM_REGS*32 flattened control registers
//   reset     reg_out[0]
//   data_en   reg_out[1]
//   wr_pulse  NUM_REGS per-register write strobes (macro-enabled only)
// ---------------------------------------------------------------------------
module axi_lite_regs #(
  parameter int NUM_REGS   = 4,
  parameter int NUM_STAT   = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  // write address channel
  input  logic [31:0]              s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     m_axi_awready,
  // write data channel
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     m_axi_wready,
  // write response channel
  output logic [1:0]               m_axi_bresp,
  output logic                     m_axi_bvalid,
  input  logic                     s_axi_bready,
  // read address channel
  input  logic [31:0]              s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     m_axi_arready,
  // read data channel
  output logic [31:0]              m_axi_rdata,
  output logic [1:0]               m_axi_rresp,
  output logic                     m_axi_rvalid,
  input  logic                     s_axi_rready,
  // register file side
  input  logic [NUM_STAT*32-1:0]   stat_in,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic                     reset,
  output logic                     data_en
`ifdef AXI_LITE_REGS_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]      wr_pulse
`endif
);

  localparam int         IDX_W       = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  w_state_t          w_state_reg;
  logic              aw_held_reg;
  logic              w_held_reg;
  logic              awready_reg;
  logic              wready_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;
  logic [IDX_W-1:0]  wr_idx_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;

  r_state_t          r_state_reg;
  logic              arready_reg;
  logic              rvalid_reg;
  logic [31:0]       rdata_reg;
  logic [1:0]        rresp_reg;

  logic [31:0]       ctrl_mem_reg [NUM_REGS];

  // -------------------------------------------------------------------------
  // Handshakes and address decode
  // -------------------------------------------------------------------------
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_commit;
  logic              wr_decoded;
  logic [IDX_W-1:0]  rd_idx;
  logic [NUM_REGS-1:0] wr_ctrl_sel;
  logic [NUM_REGS-1:0] rd_ctrl_sel;
  logic [NUM_STAT-1:0] rd_stat_sel;
  logic [31:0]       rd_data_next;
  logic [1:0]        rd_resp_next;

  // The ready flags are registered, so a handshake is simply valid & ready.
  assign aw_hs  = s_axi_awvalid & awready_reg;
  assign w_hs   = s_axi_wvalid  & wready_reg;
  assign ar_hs  = s_axi_arvalid & arready_reg;
  assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  // The commit happens on the edge after both halves are held. This keeps the
  // register update off the capture edge, so AW and W need no ordering.
  assign wr_commit = (w_state_reg == W_IDLE) & aw_held_reg & w_held_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl_dec
      assign wr_ctrl_sel[gi] = (wr_idx_reg == IDX_W'(gi));
      assign rd_ctrl_sel[gi] = (rd_idx     == IDX_W'(gi));
      assign reg_out[32*gi +: 32] = ctrl_mem_reg[gi];
    end
    for (gi = 0; gi < NUM_STAT; gi++) begin : g_stat_dec
      assign rd_stat_sel[gi] = (rd_idx == IDX_W'(NUM_REGS + gi));
    end
  endgenerate

  // Writes are accepted only for control indices. Status and undecoded
  // indices are refused.
  assign wr_decoded = |wr_ctrl_sel;

  // -------------------------------------------------------------------------
  // Write channel FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      wr_idx_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      unique case (w_state_reg)
        W_IDLE: begin
          if (wr_commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_decoded ? RESP_OKAY : RESP_SLVERR;
            w_state_reg <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held_reg <= 1'b1;
              wr_idx_reg  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_held_reg <= 1'b1;
              wdata_reg  <= s_axi_wdata;
              wstrb_reg  <= s_axi_wstrb;
            end
            // Each ready drops as soon as its half is captured. This also
            // raises both readies on the first edge after reset release.
            awready_reg <= ~(aw_held_reg | aw_hs);
            wready_reg  <= ~(w_held_reg  | w_hs);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control registers with per-byte strobes. A zero strobe still counts as a
  // successful write, but it leaves the register unchanged.
  // -------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        ctrl_mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_commit && wr_ctrl_sel[i] && wstrb_reg[b]) begin
            ctrl_mem_reg[i][8*b +: 8] <= wdata_reg[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef AXI_LITE_REGS_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_reg;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= wr_commit ? wr_ctrl_sel : '0;
    end
  end

  assign wr_pulse = wr_pulse_reg;
`endif

  // -------------------------------------------------------------------------
  // Read data mux. It sees the registers as they stand before this edge, so a
  // read colliding with a commit returns the old value.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_ctrl_sel[i]) begin
        rd_data_next = ctrl_mem_reg[i];
        rd_resp_next = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (rd_stat_sel[j]) begin
        rd_data_next = stat_in[32*j +: 32];
        rd_resp_next = RESP_OKAY;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read channel FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      unique case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_reg   <= rd_data_next;
            rresp_reg   <= rd_resp_next;
            rvalid_reg  <= 1'b1;
            arready_reg <= 1'b0;
            r_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m_axi_awready = awready_reg;
  assign m_axi_wready  = wready_reg;
  assign m_axi_bvalid  = bvalid_reg;
  assign m_axi_bresp   = bresp_reg;
  assign m_axi_arready = arready_reg;
  assign m_axi_rvalid  = rvalid_reg;
  assign m_axi_rdata   = rdata_reg;
  assign m_axi_rresp   = rresp_reg;

  assign reset   = ctrl_mem_reg[0][0];
  assign data_en = ctrl_mem_reg[0][1];

  // Protection bits and the address bits outside the decoded field are
  // deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[1:0], s_axi_awaddr[31:ADDR_WIDTH],
                           s_axi_araddr[1:0], s_axi_araddr[31:ADDR_WIDTH]};

endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

Parametrised AXI4-Lite slave register file; successor to the fixed two-register control block in the AD9643 capture path. Provides NUM_REGS read/write control registers and NUM_STAT read-only status registers. Read and write channels are independent, byte strobes are honoured and undecoded addresses return SLVERR. Register 0 bits 0 and 1 still drive the ADC-path `reset` and `data_en` controls.

## Interface
- NUM_REGS, 4: number of R/W 32-bit control registers, at byte offsets 0x0, 0x4, …
- NUM_STAT, 2: number of read-only 32-bit status registers, immediately following the control registers.
- ADDR_WIDTH, 8: decoded address bits. Bits [1:0] are ignored and bits above ADDR_WIDTH-1 are ignored. Required: NUM_REGS+NUM_STAT ≤ 2^(ADDR_WIDTH-2).

Ports:
- s_axi_aclk  in  1  single clock; one clock, all logic on rising edge.
- s_axi_aresetn  in  1  reset is asynchronous and active-low.
- s_axi_awaddr/s_axi_araddr  in  32  byte addresses.
- s_axi_awprot/s_axi_arprot  in  3  accepted and ignored.
- s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready  in  1  AXI handshakes.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid  out  1  AXI handshakes.
- m_axi_bresp/m_axi_rresp  out  2  responses: 00 OKAY, 10 SLVERR.
- m_axi_rdata  out  32  read data.
- stat_in  in  NUM_STAT*32  status values. Register j is bits [32j+31:32j]; sampled at AR handshake.
- reg_out  out  NUM_REGS*32  control registers, flattened. Register i is bits [32i+31:32i].
- reset  out  1  reg_out[0].
- data_en  out  1  reg_out[1].
- wr_pulse  out  NUM_REGS  only with AXI_LITE_REGS_WR_PULSE_EN; see Configuration.

## Operation
- Index decode: idx = addr[ADDR_WIDTH-1:2].
  - idx < NUM_REGS: control register.
  - NUM_REGS ≤ idx < NUM_REGS+NUM_STAT: status register.
  - Otherwise: undecoded.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
  - awready is high until AW is captured; wready is high until W is captured.
  - Once both are held, the next edge commits the write, sets bvalid and enters W_RESP.
  - W_RESP holds bvalid/bresp stable until bready. On that edge, return to W_IDLE with awready=wready=1.
- Write commit rules:
  - Only bytes with wstrb[k]=1 update the control register.
  - wstrb=0000 is legal: no change, OKAY response.
  - A write to a status or undecoded index changes nothing and returns bresp=10.
- Read FSM states: R_IDLE, R_DATA.
  - arready=1 in R_IDLE.
  - On the AR handshake edge, rdata/rresp are registered and the FSM enters R_DATA with rvalid=1.
  - rdata: control register value, stat_in slice, or 0 with rresp=10 for undecoded indices.
  - R_DATA holds rdata/rvalid stable until rready, then returns to R_IDLE.
- Read/write collisions:
  - Reads and writes proceed concurrently.
  - If the AR handshake and the write commit to the same register occur on the same edge, the read returns the pre-write value.
- Reset (asynchronous, any time including mid-transaction):
  - All control registers = 0, bvalid=rvalid=0, rdata=0, bresp=rresp=00.
  - awready=wready=arready=1 one cycle after deassertion. They are 0 while aresetn is low.
  - Held AW/W captures are discarded.

## Timing
- Write, with AW and W presented together at edge T:
  - reg_out updates at T+1.
  - bvalid=1 after T+1.
  - Minimum cycle: 3 clocks per write with bready tied high.
- Read, with AR accepted at edge T: rvalid=1 after T. Back-to-back reads every 2 clocks with rready tied high.
- reset/data_en follow reg_out combinationally. No extra latency.

## Configuration
- AXI_LITE_REGS_WR_PULSE_EN defined:
  - wr_pulse[i] is a one-cycle registered pulse, high for the cycle after the edge that commits any successful write to control register i, including wstrb=0000.
  - wr_pulse is 0 in reset.
- Not defined: the wr_pulse port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write 0x0000_0003 to 0x0, strobe 1111 → bresp=00, reg_out[31:0]=0x3, reset=1, data_en=1; read 0x0 returns 0x3 with rresp=00.
- W presented 3 cycles before AW (addr 0x4, data 0xAABBCCDD, wstrb 0101) on a register holding 0x11223344 → register=0x11BB33DD; bvalid exactly one cycle after AW is captured.
- Read at 0x8 with stat_in[31:0]=0xDEADBEEF (NUM_REGS=2) → rdata=0xDEADBEEF, OKAY. Write to 0x8 → bresp=10 and no register changes. Read at 0xFC → rdata=0, rresp=10.
- rready held low 5 cycles, then high → rvalid and rdata stable throughout; arready low until the handshake completes. Concurrent write to the same register commits and does not alter the pending rdata.
- aresetn pulsed low while bvalid is pending → bvalid=0 immediately, all registers 0, ready signals return to 1. With the macro enabled: a write to 0x4 gives wr_pulse=0b10 for exactly one cycle.
